serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state type and the
// constant clog2 helper used to size the bit counter.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Ceiling log2 for elaboration-time sizing; clog2(1) returns 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned x = v - 1; x > 0; x = x >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell: s = a ^ b ^ ci, co = majority(a, b, ci).
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts {a, b, c_in} through a valid/ready handshake,
// adds one bit pair per clock LSB first through a full_adder cell with the
// carry recirculated through a flop, then presents {c_out, sum} through a
// valid/ready handshake.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             busy
);

   localparam int unsigned   CW   = clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry;
   logic [CW-1:0]    count;
   logic             fa_s;
   logic             fa_co;
   logic             last_bit;

   assign last_bit = (count == LAST);

   full_adder u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; the unused encoding falls back to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid)  state_nxt = S_RUN;
         S_RUN:   if (last_bit)  state_nxt = S_DONE;
         S_DONE:  if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the state.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         S_IDLE:  in_ready  = 1'b1;
         S_RUN:   busy      = 1'b1;
         S_DONE:  begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   // Operand shifters, carry flop, bit counter and result registers.
   // The counter returns to 0 on the last bit so it never exceeds WIDTH-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         count  <= '0;
         sum    <= '0;
         c_out  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= c_in;
                  count <= '0;
               end
            end
            S_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
               carry  <= fa_co;
               if (last_bit) begin
                  sum   <= {fa_s, sum_sh[WIDTH-1:1]};
                  c_out <= fa_co;
                  count <= '0;
               end else begin
                  count <= count + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16: directed
// vector table, backpressure and mid-run reset sequences, random sweep.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       iv8 = 1'b0, or8 = 1'b1, ci8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       ir8, ov8, co8, bsy8;
   logic [7:0] s8;

   logic        iv16 = 1'b0, or16 = 1'b1, ci16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        ir16, ov16, co16, bsy16;
   logic [15:0] s16;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
      .a(a8), .b(b8), .c_in(ci8), .out_valid(ov8), .out_ready(or8),
      .sum(s8), .c_out(co8), .busy(bsy8)
   );

   serial_adder #(.WIDTH(16)) u16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .c_in(ci16), .out_valid(ov16), .out_ready(or16),
      .sum(s16), .c_out(co16), .busy(bsy16)
   );

   typedef struct {
      int          w;
      logic [31:0] a;
      logic [31:0] b;
      logic        ci;
      logic [31:0] es;
      logic        eco;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic sample(input int w, output logic rdy, output logic ov, output logic bsy,
                         output logic [31:0] s, output logic co);
      if (w == 8) begin
         rdy = ir8; ov = ov8; bsy = bsy8; s = {24'h0, s8}; co = co8;
      end else begin
         rdy = ir16; ov = ov16; bsy = bsy16; s = {16'h0, s16}; co = co16;
      end
   endtask

   // One complete add on the selected instance, starting #1 after a rising edge.
   task automatic run_add(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic ordy, input string nm);
      logic rdy, ov, bsy, co;
      logic [31:0] s;
      longint unsigned tot;
      logic [31:0] es;
      logic eco;
      int lat, bcnt;
      tot = longint'(a) + longint'(b) + longint'(ci);
      es  = 32'(tot & ((64'd1 << w) - 1));
      eco = tot[w];
      sample(w, rdy, ov, bsy, s, co);
      check({nm, " in_ready"}, {31'h0, rdy}, 32'd1);
      if (w == 8) begin
         a8 = a[7:0]; b8 = b[7:0]; ci8 = ci; iv8 = 1'b1; or8 = ordy;
      end else begin
         a16 = a[15:0]; b16 = b[15:0]; ci16 = ci; iv16 = 1'b1; or16 = ordy;
      end
      @(posedge clk); #1;
      iv8 = 1'b0; iv16 = 1'b0;
      lat = 1; bcnt = 0;
      sample(w, rdy, ov, bsy, s, co);
      while (!ov && lat < w + 10) begin
         if (bsy) bcnt++;
         @(posedge clk); #1;
         lat++;
         sample(w, rdy, ov, bsy, s, co);
      end
      if (bsy) bcnt++;
      check({nm, " latency"}, 32'(lat), 32'(w + 1));
      check({nm, " busy_cycles"}, 32'(bcnt), 32'(w + 1));
      check({nm, " sum"}, s, es);
      check({nm, " c_out"}, {31'h0, co}, {31'h0, eco});
      if (ordy) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      vec_t tbl[6];
      logic rdy, ov, bsy, co;
      logic [31:0] s, ra, rb;
      int w;

      tbl[0] = '{8,  32'h00,   32'h00,   1'b0, 32'h00,   1'b0};
      tbl[1] = '{8,  32'h3C,   32'h42,   1'b0, 32'h7E,   1'b0};
      tbl[2] = '{8,  32'hFF,   32'h01,   1'b0, 32'h00,   1'b1};
      tbl[3] = '{8,  32'hA5,   32'h5A,   1'b1, 32'h00,   1'b1};
      tbl[4] = '{16, 32'hFFFF, 32'hFFFF, 1'b1, 32'hFFFF, 1'b1};
      tbl[5] = '{8,  32'h80,   32'h7F,   1'b1, 32'h00,   1'b1};

      // Reset state without any clock edge.
      #1;
      sample(8, rdy, ov, bsy, s, co);
      check("rst in_ready", {31'h0, rdy}, 32'd1);
      check("rst out_valid", {31'h0, ov}, 32'd0);
      check("rst busy", {31'h0, bsy}, 32'd0);
      check("rst sum", s, 32'd0);
      check("rst c_out", {31'h0, co}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table: expected values are written out, not computed.
      for (int i = 0; i < 6; i++) begin
         run_add(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].ci, 1'b1, $sformatf("vec%0d", i));
         sample(tbl[i].w, rdy, ov, bsy, s, co);
         check($sformatf("vec%0d tbl_sum", i), s, tbl[i].es);
         check($sformatf("vec%0d tbl_cout", i), {31'h0, co}, {31'h0, tbl[i].eco});
         check($sformatf("vec%0d idle_ready", i), {31'h0, rdy}, 32'd1);
      end

      // Backpressure: result held, new operands refused while DONE.
      run_add(8, 32'h33, 32'h44, 1'b0, 1'b0, "bp");
      iv8 = 1'b1; a8 = 8'h11; b8 = 8'h11;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         sample(8, rdy, ov, bsy, s, co);
         check("bp out_valid", {31'h0, ov}, 32'd1);
         check("bp in_ready", {31'h0, rdy}, 32'd0);
         check("bp sum", s, 32'h77);
         check("bp c_out", {31'h0, co}, 32'd0);
      end
      or8 = 1'b1; iv8 = 1'b0;
      @(posedge clk); #1;
      sample(8, rdy, ov, bsy, s, co);
      check("bp release in_ready", {31'h0, rdy}, 32'd1);
      check("bp release out_valid", {31'h0, ov}, 32'd0);
      check("bp idle sum hold", s, 32'h77);
      repeat (3) @(posedge clk);
      #1;
      sample(8, rdy, ov, bsy, s, co);
      check("bp no stray accept", {31'h0, bsy}, 32'd0);

      // Reset mid-run at count=3, asserted between clock edges.
      a8 = 8'hF0; b8 = 8'h0F; ci8 = 1'b1; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      sample(8, rdy, ov, bsy, s, co);
      check("mid rst in_ready", {31'h0, rdy}, 32'd1);
      check("mid rst out_valid", {31'h0, ov}, 32'd0);
      check("mid rst busy", {31'h0, bsy}, 32'd0);
      check("mid rst sum", s, 32'd0);
      check("mid rst c_out", {31'h0, co}, 32'd0);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      sample(8, rdy, ov, bsy, s, co);
      check("post rst out_valid", {31'h0, ov}, 32'd0);
      run_add(8, 32'h01, 32'h01, 1'b0, 1'b1, "post rst add");

      // Random sweep checked against plain integer addition.
      for (int i = 0; i < 200; i++) begin
         w  = (i % 2 == 0) ? 16 : 8;
         ra = $urandom & ((32'd1 << w) - 1);
         rb = $urandom & ((32'd1 << w) - 1);
         run_add(w, ra, rb, 1'($urandom_range(0, 1)), 1'b1, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
